// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART receiver.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    localparam int OVERSAMPLE  = 16;
endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus 2-of-3 majority voter around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk2,
    input  logic       rst,
    input  logic       tick16,
    input  logic       rx,
    input  logic [3:0] cnt,
    output logic       rx_sync,
    output logic       maj
);
    localparam logic [3:0] MID = 4'(OVERSAMPLE / 2);

    logic meta;
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            meta    <= 1'b1;
            rx_sync <= 1'b1;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
        end else begin
            meta    <= rx;
            rx_sync <= meta;
            if (tick16 && cnt == MID - 4'd1) samp_a <= rx_sync;
            if (tick16 && cnt == MID)        samp_b <= rx_sync;
        end
    end

    // Third vote is the live sample, so the result is meaningful on the count-9 tick.
    assign maj = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with configurable data width, parity and stop bits.
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | validating start bit
// DATA   | shifting data bits, LSB first
// PARITY | capturing parity bit
// STOP   | checking stop bit(s), frame completes at centre of last
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic                 tick16,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);
    localparam logic [3:0] LAST_CNT  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] DEC_CNT   = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_t state, state_n;
    logic [3:0]           cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit;
    logic                 ferr_acc;
    logic                 first_zero;
    logic                 done;
    logic                 pend_perr, pend_ferr, pend_brk;
    logic                 rx_sync, maj;
    logic                 shift_en, pbit_en, stop_en, frame_end, bit_end, dec;

    uart_rx_sampler u_sampler (
        .clk2    (clk2),
        .rst     (rst),
        .tick16  (tick16),
        .rx      (rx),
        .cnt     (cnt),
        .rx_sync (rx_sync),
        .maj     (maj)
    );

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (tick16) begin
            case (state)
                ST_IDLE:   if (!rx_sync) state_n = ST_START;
                ST_START: begin
                    if (cnt == DEC_CNT && maj) state_n = ST_IDLE;
                    else if (cnt == LAST_CNT)  state_n = ST_DATA;
                end
                ST_DATA:
                    if (cnt == LAST_CNT && bit_idx == LAST_BIT)
                        state_n = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                ST_PARITY: if (cnt == LAST_CNT) state_n = ST_STOP;
                ST_STOP:   if (cnt == DEC_CNT && stop_idx == LAST_STOP) state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dec       = tick16 && (cnt == DEC_CNT);
        bit_end   = tick16 && (cnt == LAST_CNT);
        shift_en  = dec && (state == ST_DATA);
        pbit_en   = dec && (state == ST_PARITY);
        stop_en   = dec && (state == ST_STOP);
        frame_end = stop_en && (stop_idx == LAST_STOP);
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            pbit       <= 1'b0;
            ferr_acc   <= 1'b0;
            first_zero <= 1'b0;
            done       <= 1'b0;
            pend_perr  <= 1'b0;
            pend_ferr  <= 1'b0;
            pend_brk   <= 1'b0;
        end else begin
            done <= frame_end;
            if (tick16) cnt <= (state == ST_IDLE) ? 4'd0 : cnt + 4'd1;
            if (state == ST_IDLE) begin
                bit_idx    <= '0;
                stop_idx   <= 1'b0;
                pbit       <= 1'b0;
                ferr_acc   <= 1'b0;
                first_zero <= 1'b0;
            end
            if (bit_end && state == ST_DATA)
                bit_idx <= (bit_idx == LAST_BIT) ? 4'd0 : bit_idx + 4'd1;
            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (pbit_en)  pbit  <= maj;
            if (stop_en) begin
                ferr_acc <= ferr_acc | ~maj;
                if (!stop_idx) first_zero <= ~maj;
            end
            if (bit_end && state == ST_STOP) stop_idx <= ~stop_idx;
            if (frame_end) begin
                pend_ferr <= ferr_acc | ~maj;
                pend_brk  <= ~(|shreg) && ~pbit && (stop_idx ? first_zero : ~maj);
                case (PARITY_MODE)
                    PARITY_EVEN: pend_perr <= ^{shreg, pbit};
                    PARITY_ODD:  pend_perr <= ~(^{shreg, pbit});
                    default:     pend_perr <= 1'b0;
                endcase
            end
        end
    end

    // A completed frame is only dropped when the previous one is still unaccepted.
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                parity_err <= pend_perr;
                frame_err  <= pend_ferr;
                break_det  <= pend_brk;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param in 8E1 configuration.
module tb_uart_rx_param;
    logic       clk2 = 1'b0;
    logic       rst = 1'b0;
    logic       tick16 = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, break_det, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int vcyc = 0;
    int ovr_cnt = 0;
    int tc = 0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .tick16     (tick16),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .overrun    (overrun)
    );

    always #5 clk2 = ~clk2;

    // 16x tick every 4th clk2 cycle, changed away from the active edge.
    initial begin
        forever begin
            @(posedge clk2);
            #2;
            tc = tc + 1;
            tick16 = (tc % 4 == 0);
        end
    end

    always @(negedge clk2) begin
        if (rx_valid) vcyc = vcyc + 1;
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (rx_valid && rx_ready) begin
            acc_cnt  = acc_cnt + 1;
            cap_data = rx_data;
            cap_perr = parity_err;
            cap_ferr = frame_err;
            cap_brk  = break_det;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk2);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk2);
        #2 rx = b;
        repeat (63) @(posedge clk2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pb);
        drive_bit(sb);
        drive_bit(1'b1);
        cycles(32);
    endtask

    task automatic check_frame(input string name, input int acc0, input logic [7:0] d,
                               input logic pe, input logic fe, input logic bk);
        n_cmp++;
        if (acc_cnt !== acc0 + 1) begin
            n_bad++;
            $display("FAIL %s_count: got %0d deliveries, want %0d", name, acc_cnt - acc0, 1);
        end
        n_cmp++;
        if (cap_data !== d) begin
            n_bad++;
            $display("FAIL %s_data: got %h want %h", name, cap_data, d);
        end
        n_cmp++;
        if ({cap_perr, cap_ferr, cap_brk} !== {pe, fe, bk}) begin
            n_bad++;
            $display("FAIL %s_flags(p,f,b): got %b want %b", name,
                     {cap_perr, cap_ferr, cap_brk}, {pe, fe, bk});
        end
    endtask

    task automatic test_reset();
        cycles(5);
        n_cmp++;
        if ({rx_valid, parity_err, frame_err, break_det, overrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {rx_valid, parity_err, frame_err, break_det, overrun});
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", rx_data);
        end
        #1 rst = 1'b1;
        cycles(20);
    endtask

    task automatic test_good_frame();
        int a0 = acc_cnt;
        int v0 = vcyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        check_frame("good_a5", a0, 8'hA5, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (vcyc - v0 !== 1) begin
            n_bad++;
            $display("FAIL good_valid_cycles: got %0d want 1", vcyc - v0);
        end
    endtask

    task automatic test_parity_err();
        int a0 = acc_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        check_frame("parity_a5", a0, 8'hA5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_false_start();
        int a0 = acc_cnt;
        @(posedge clk2);
        #2 rx = 1'b0;
        cycles(16);
        rx = 1'b1;
        cycles(200);
        n_cmp++;
        if (acc_cnt !== a0 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL false_start: got %0d deliveries valid=%b want 0 valid=0",
                     acc_cnt - a0, rx_valid);
        end
        a0 = acc_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        check_frame("after_false_3c", a0, 8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_break();
        int a0 = acc_cnt;
        send_frame(8'h00, 1'b0, 1'b0);
        cycles(128);
        check_frame("break_00", a0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_overrun();
        int a0 = acc_cnt;
        int o0 = ovr_cnt;
        @(posedge clk2);
        #2 rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        @(negedge clk2);
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            n_bad++;
            $display("FAIL ovr_first_held: got valid=%b data=%h want valid=1 data=11",
                     rx_valid, rx_data);
        end
        send_frame(8'h22, 1'b0, 1'b1);
        @(negedge clk2);
        n_cmp++;
        if (ovr_cnt - o0 !== 1) begin
            n_bad++;
            $display("FAIL ovr_pulse: got %0d overrun cycles want 1", ovr_cnt - o0);
        end
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            n_bad++;
            $display("FAIL ovr_data_kept: got valid=%b data=%h want valid=1 data=11",
                     rx_valid, rx_data);
        end
        @(posedge clk2);
        #2 rx_ready = 1'b1;
        @(posedge clk2);
        @(negedge clk2);
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_clear: got valid=%b want 0", rx_valid);
        end
        check_frame("ovr_accept", a0, 8'h11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int a0;
        logic [7:0] d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        @(posedge clk2);
        #2 rst = 1'b0;
        rx = 1'b1;
        @(negedge clk2);
        n_cmp++;
        if ({rx_valid, parity_err, frame_err, break_det, overrun} !== 5'b0 || rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got flags=%b data=%h want 00000 data=00",
                     {rx_valid, parity_err, frame_err, break_det, overrun}, rx_data);
        end
        cycles(10);
        rst = 1'b1;
        cycles(40);
        a0 = acc_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        check_frame("post_reset_3c", a0, 8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_false_start();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 The block SHALL have parameter PARITY_MODE, default 1, 0 = none, 1 = even, 2 = odd.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, stop bits checked, legal 1..2.
REQ-004 The block SHALL have port clk2, input, 1, single system clock; all logic on posedge clk2.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port tick16, input, 1, one-clk2 pulse at 16x baud rate (sample enable).
REQ-007 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-008 The block SHALL have port rx_ready, input, 1, consumer accepts rx_data this cycle.
REQ-009 The block SHALL have port rx_data, output, DATA_BITS, received word, LSB first on the line.
REQ-010 The block SHALL have port rx_valid, output, 1, rx_data and status flags valid.
REQ-011 The block SHALL have ports parity_err, frame_err and break_det, output, 1 each, status qualified by rx_valid.
REQ-012 The block SHALL have port overrun, output, 1, one-clk2 pulse when a completed frame is dropped.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer before use; latency 2 clk2 cycles.
REQ-014 All timing SHALL advance only on tick16; a 4-bit sample counter SHALL count 0..15 per bit period.
REQ-015 The bit value SHALL be the 2-of-3 majority of samples at counts 7, 8 and 9, decided at count 9.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START SHALL occur on the first tick16 with synced rx = 0; the counter SHALL clear.
REQ-018 In START, a majority of 1 SHALL return the FSM to IDLE (false start) with no output.
REQ-019 START->DATA SHALL occur at count 15; DATA SHALL shift DATA_BITS bits LSB first.
REQ-020 DATA SHALL go to PARITY when PARITY_MODE != 0 and to STOP otherwise.
REQ-021 The parity check SHALL flag even mode when XOR(data, pbit) = 1 and odd mode when XOR(data, pbit) = 0.
REQ-022 STOP SHALL check STOP_BITS bits; any stop majority 0 SHALL set frame_err.
REQ-023 break_det SHALL be 1 when the data is all zero, parity is 0 or absent, and the first stop bit is 0.
REQ-024 At count 9 of the last stop bit, the FSM SHALL return to IDLE and deliver the frame in the next clk2 cycle.
REQ-025 rx_valid SHALL stay high with data and flags stable until a cycle with rx_ready = 1; it SHALL then clear.
REQ-026 A frame completing while rx_valid = 1 and rx_ready = 0 SHALL be dropped; overrun SHALL pulse and the old data SHALL be kept.
REQ-027 Frame completion and rx_ready = 1 in the same cycle SHALL load the new frame, keep rx_valid = 1, and not pulse overrun.
REQ-028 A frame with errors SHALL still be delivered, with its flags set.
REQ-029 tick16 absent SHALL freeze the FSM and counters.

Reset
REQ-030 On rst = 0, asynchronously: FSM SHALL go to IDLE; counters, shift register, rx_data, rx_valid, parity_err, frame_err, break_det and overrun SHALL go to 0; synchronizer flops SHALL go to 1.
REQ-031 Reset mid-frame SHALL discard the partial frame; reception SHALL restart at the next falling edge after release.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state typedef, PARITY_NONE/EVEN/ODD constants, and OVERSAMPLE = 16.
REQ-033 Sub-module uart_rx_sampler SHALL contain the synchronizer and 3-sample majority voter.

Verification
REQ-034 8E1 frame 0xA5 with pbit 0 and rx_ready = 1 -> rx_data = 0xA5, rx_valid for 1 cycle, all flags 0.
REQ-035 8E1 frame 0xA5 with pbit 1 -> rx_data = 0xA5, parity_err = 1.
REQ-036 rx low for 4 ticks then high -> no rx_valid; following frame 0x3C is received correctly.
REQ-037 Stop bit 0 on frame 0x00 with pbit 0 -> frame_err = 1, break_det = 1.
REQ-038 Frames 0x11 then 0x22 with rx_ready = 0 -> overrun pulse at second completion; rx_data stays 0x11.
REQ-039 rst asserted after data bit 3 of 0x5A, then frame 0x3C -> outputs 0 during reset; rx_data = 0x3C, no flags.
